// File: rtl/texture_pkg.sv
// Shared asset enumeration, image geometry and SDRAM layout for the texture loader.
package texture_pkg;

    typedef enum logic [1:0] {
        BIRD = 2'd0,
        PIPE = 2'd1,
        BASE = 2'd2
    } asset_e;

    localparam int unsigned SDRAM_AW = 24;
    localparam int unsigned LEN_W    = 9;
    localparam int unsigned OFFSET_W = 16;

    localparam int unsigned BIRD_WORDS = 5250;
    localparam int unsigned PIPE_WORDS = 40000;
    localparam int unsigned BASE_WORDS = 9600;

    localparam logic [SDRAM_AW-1:0] BIRD_SDRAM_ADDR = 24'h200000;
    localparam logic [SDRAM_AW-1:0] PIPE_SDRAM_ADDR = 24'h202000;
    localparam logic [SDRAM_AW-1:0] BASE_SDRAM_ADDR = 24'h20C000;

    // Must stay within 1..256 so a length always fits LEN_W bits.
    localparam int unsigned BURST_LEN = 256;

    function automatic asset_e next_asset(input asset_e a);
        case (a)
            BIRD:    return PIPE;
            default: return BASE;
        endcase
    endfunction

endpackage

// File: rtl/burst_splitter.sv
// Cuts an asset into bursts of at most BurstLen words and keeps the running word offset.
module burst_splitter
    import texture_pkg::*;
#(
    parameter int unsigned BurstLen = BURST_LEN
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [OFFSET_W-1:0] words_i,
    input  logic                clear_i,
    input  logic                advance_i,
    output logic [OFFSET_W-1:0] offset_o,
    output logic [LEN_W-1:0]    len_o,
    output logic                last_o
);

    logic [OFFSET_W-1:0] offset_d, offset_q;
    logic [OFFSET_W-1:0] remain;

    always_comb begin
        remain   = words_i - offset_q;
        last_o   = (remain <= OFFSET_W'(BurstLen));
        len_o    = last_o ? remain[LEN_W-1:0] : LEN_W'(BurstLen);
        offset_d = offset_q;
        if (clear_i) begin
            offset_d = '0;
        end else if (advance_i) begin
            offset_d = offset_q + OFFSET_W'(len_o);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            offset_q <= '0;
        end else begin
            offset_q <= offset_d;
        end
    end

    assign offset_o = offset_q;

endmodule

// File: rtl/texture_load_ctrl.sv
// Texture loader: streams bird, pipe and base images from SDRAM into the renderer's texture RAMs.
// Define TEXTURE_LOAD_CHECKSUM_EN to add per-asset modulo-2^16 word sums.
module texture_load_ctrl
    import texture_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        req_valid,
    input  logic        req_ready,
    output logic [23:0] req_addr,
    output logic [8:0]  req_len,
    input  logic        rd_valid,
    input  logic [15:0] rd_data,
    output logic [15:0] load_data,
    output logic        bird_load_en,
    output logic [12:0] bird_load_addr,
    output logic        pipe_load_en,
    output logic [15:0] pipe_load_addr,
    output logic        base_load_en,
    output logic [13:0] base_load_addr,
    output logic        busy,
    output logic        done
`ifdef TEXTURE_LOAD_CHECKSUM_EN
    ,
    output logic [15:0] bird_sum,
    output logic [15:0] pipe_sum,
    output logic [15:0] base_sum
`endif
);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StReq  = 2'd1;
    localparam logic [1:0] StRecv = 2'd2;
    localparam logic [1:0] StDone = 2'd3;

    logic [1:0]          state_d, state_q;
    asset_e              asset_d, asset_q;
    logic [LEN_W-1:0]    burst_cnt_d, burst_cnt_q;
    logic [LEN_W-1:0]    pos_d, pos_q;
    logic                wr_en_d, wr_en_q;
    asset_e              wr_asset_d, wr_asset_q;
    logic [OFFSET_W-1:0] wr_addr_d, wr_addr_q;
    logic [15:0]         load_data_d, load_data_q;
    logic                busy_d, busy_q;
    logic                done_d, done_q;

    logic [OFFSET_W-1:0] words;
    logic [OFFSET_W-1:0] offset;
    logic [SDRAM_AW-1:0] base_addr;
    logic [LEN_W-1:0]    burst_len;
    logic                burst_last;
    logic                off_clear, off_advance;
    logic                start_ok;

    always_comb begin
        case (asset_q)
            PIPE: begin
                words     = OFFSET_W'(PIPE_WORDS);
                base_addr = PIPE_SDRAM_ADDR;
            end
            BASE: begin
                words     = OFFSET_W'(BASE_WORDS);
                base_addr = BASE_SDRAM_ADDR;
            end
            default: begin
                words     = OFFSET_W'(BIRD_WORDS);
                base_addr = BIRD_SDRAM_ADDR;
            end
        endcase
    end

    burst_splitter #(
        .BurstLen (BURST_LEN)
    ) u_splitter (
        .clk_i     (clk),
        .rst_i     (rst),
        .words_i   (words),
        .clear_i   (off_clear),
        .advance_i (off_advance),
        .offset_o  (offset),
        .len_o     (burst_len),
        .last_o    (burst_last)
    );

    assign start_ok = start && ((state_q == StIdle) || (state_q == StDone));

    always_comb begin
        state_d     = state_q;
        asset_d     = asset_q;
        burst_cnt_d = burst_cnt_q;
        pos_d       = pos_q;
        wr_en_d     = 1'b0;
        wr_asset_d  = wr_asset_q;
        wr_addr_d   = wr_addr_q;
        load_data_d = load_data_q;
        busy_d      = busy_q;
        done_d      = done_q;
        off_clear   = 1'b0;
        off_advance = 1'b0;

        case (state_q)
            StIdle, StDone: begin
                if (start_ok) begin
                    asset_d   = BIRD;
                    off_clear = 1'b1;
                    done_d    = 1'b0;
                    busy_d    = 1'b1;
                    state_d   = StReq;
                end
            end
            StReq: begin
                if (req_ready) begin
                    burst_cnt_d = burst_len;
                    pos_d       = '0;
                    state_d     = StRecv;
                end
            end
            StRecv: begin
                if (rd_valid) begin
                    wr_en_d     = 1'b1;
                    wr_asset_d  = asset_q;
                    wr_addr_d   = offset + OFFSET_W'(pos_q);
                    load_data_d = rd_data;
                    pos_d       = pos_q + LEN_W'(1);
                    burst_cnt_d = burst_cnt_q - LEN_W'(1);
                    if (burst_cnt_q == LEN_W'(1)) begin
                        if (!burst_last) begin
                            off_advance = 1'b1;
                            state_d     = StReq;
                        end else if (asset_q != BASE) begin
                            asset_d   = next_asset(asset_q);
                            off_clear = 1'b1;
                            state_d   = StReq;
                        end else begin
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                            state_d = StDone;
                        end
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            asset_q     <= BIRD;
            burst_cnt_q <= '0;
            pos_q       <= '0;
            wr_en_q     <= 1'b0;
            wr_asset_q  <= BIRD;
            wr_addr_q   <= '0;
            load_data_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            asset_q     <= asset_d;
            burst_cnt_q <= burst_cnt_d;
            pos_q       <= pos_d;
            wr_en_q     <= wr_en_d;
            wr_asset_q  <= wr_asset_d;
            wr_addr_q   <= wr_addr_d;
            load_data_q <= load_data_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    // Request fields read as zero outside REQ so idle outputs stay quiet.
    assign req_valid      = (state_q == StReq);
    assign req_addr       = req_valid ? (base_addr + SDRAM_AW'(offset)) : '0;
    assign req_len        = req_valid ? burst_len : '0;
    assign load_data      = load_data_q;
    assign bird_load_en   = wr_en_q && (wr_asset_q == BIRD);
    assign pipe_load_en   = wr_en_q && (wr_asset_q == PIPE);
    assign base_load_en   = wr_en_q && (wr_asset_q == BASE);
    assign bird_load_addr = wr_addr_q[12:0];
    assign pipe_load_addr = wr_addr_q;
    assign base_load_addr = wr_addr_q[13:0];
    assign busy           = busy_q;
    assign done           = done_q;

`ifdef TEXTURE_LOAD_CHECKSUM_EN
    logic [15:0] bird_sum_d, bird_sum_q;
    logic [15:0] pipe_sum_d, pipe_sum_q;
    logic [15:0] base_sum_d, base_sum_q;

    // Summed at capture time so the totals are final by the time done rises.
    always_comb begin
        bird_sum_d = bird_sum_q;
        pipe_sum_d = pipe_sum_q;
        base_sum_d = base_sum_q;
        if (start_ok) begin
            bird_sum_d = '0;
            pipe_sum_d = '0;
            base_sum_d = '0;
        end else if ((state_q == StRecv) && rd_valid) begin
            case (asset_q)
                PIPE:    pipe_sum_d = pipe_sum_q + rd_data;
                BASE:    base_sum_d = base_sum_q + rd_data;
                default: bird_sum_d = bird_sum_q + rd_data;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bird_sum_q <= '0;
            pipe_sum_q <= '0;
            base_sum_q <= '0;
        end else begin
            bird_sum_q <= bird_sum_d;
            pipe_sum_q <= pipe_sum_d;
            base_sum_q <= base_sum_d;
        end
    end

    assign bird_sum = bird_sum_q;
    assign pipe_sum = pipe_sum_q;
    assign base_sum = base_sum_q;
`endif

endmodule

// File: tb/tb_texture_load_ctrl.sv
// Bench for texture_load_ctrl: SDRAM responder model feeding a write scoreboard plus directed steps.
// Builds with or without TEXTURE_LOAD_CHECKSUM_EN.
module tb_texture_load_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        req_valid;
    logic        req_ready;
    logic [23:0] req_addr;
    logic [8:0]  req_len;
    logic        rd_valid;
    logic [15:0] rd_data;
    logic [15:0] load_data;
    logic        bird_load_en;
    logic [12:0] bird_load_addr;
    logic        pipe_load_en;
    logic [15:0] pipe_load_addr;
    logic        base_load_en;
    logic [13:0] base_load_addr;
    logic        busy;
    logic        done;
`ifdef TEXTURE_LOAD_CHECKSUM_EN
    logic [15:0] bird_sum, pipe_sum, base_sum;
`endif

    always #10 clk = ~clk;

    texture_load_ctrl u_dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_addr       (req_addr),
        .req_len        (req_len),
        .rd_valid       (rd_valid),
        .rd_data        (rd_data),
        .load_data      (load_data),
        .bird_load_en   (bird_load_en),
        .bird_load_addr (bird_load_addr),
        .pipe_load_en   (pipe_load_en),
        .pipe_load_addr (pipe_load_addr),
        .base_load_en   (base_load_en),
        .base_load_addr (base_load_addr),
        .busy           (busy),
        .done           (done)
`ifdef TEXTURE_LOAD_CHECKSUM_EN
        ,
        .bird_sum       (bird_sum),
        .pipe_sum       (pipe_sum),
        .base_sum       (base_sum)
`endif
    );

    typedef struct {
        int          asset;
        int          idx;
        logic [15:0] data;
        int          cyc;
    } wr_t;

    typedef struct {
        logic [23:0] addr;
        logic [8:0]  len;
    } req_t;

    wr_t         sb[$];
    req_t        exp_req[$];
    logic [23:0] pending[$];

    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc = 0;
    logic        stale = 1'b0;
    logic        inject = 1'b0;
    int          wr_cnt[3];
    int          req_cnt[3];
    int          last_len[3];
    logic [23:0] last_addr[3];
    logic [15:0] exp_sum[3];
    int          total_en;
    int          pipe_max;
    int          first_bird_addr;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] img(input logic [23:0] a);
`ifdef TEXTURE_LOAD_CHECKSUM_EN
        return 16'h0001;
`else
        return a[15:0] ^ {a[7:0], a[15:8]} ^ {a[23:16], 8'h3C};
`endif
    endfunction

    function automatic void map_addr(input logic [23:0] a, output int asset, output int idx);
        if (a >= 24'h20C000) begin
            asset = 2;
            idx   = int'(a - 24'h20C000);
        end else if (a >= 24'h202000) begin
            asset = 1;
            idx   = int'(a - 24'h202000);
        end else begin
            asset = 0;
            idx   = int'(a - 24'h200000);
        end
    endfunction

    task automatic reset_model();
        exp_req.delete();
        for (int a = 0; a < 3; a++) begin
            int unsigned words;
            logic [23:0] base;
            words = (a == 0) ? 5250 : (a == 1) ? 40000 : 9600;
            base  = (a == 0) ? 24'h200000 : (a == 1) ? 24'h202000 : 24'h20C000;
            for (int unsigned off = 0; off < words; off += 256) begin
                req_t r;
                r.addr = base + 24'(off);
                r.len  = (words - off < 256) ? 9'(words - off) : 9'd256;
                exp_req.push_back(r);
            end
            wr_cnt[a]    = 0;
            req_cnt[a]   = 0;
            last_len[a]  = 0;
            last_addr[a] = '0;
            exp_sum[a]   = '0;
        end
        total_en        = 0;
        pipe_max        = 0;
        first_bird_addr = -1;
    endtask

    // SDRAM responder and write monitor; everything is sampled on the falling edge.
    task automatic sdram_model();
        wr_t         e;
        req_t        r;
        int          n_en, a, idx, ad;
        logic [23:0] w;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                sb.delete();
                if (pending.size() != 0) stale = 1'b1;
            end

            n_en = int'(bird_load_en) + int'(pipe_load_en) + int'(base_load_en);
            if (n_en > 1) check("one_hot_en", 32'(n_en), 32'd1);
            if (n_en != 0) begin
                if (sb.size() == 0) begin
                    check("unexpected_en", 32'(n_en), 32'd0);
                end else begin
                    e = sb.pop_front();
                    if (bird_load_en) begin
                        a  = 0;
                        ad = int'(bird_load_addr);
                        if (wr_cnt[0] == 0) first_bird_addr = ad;
                    end else if (pipe_load_en) begin
                        a  = 1;
                        ad = int'(pipe_load_addr);
                        if (ad > pipe_max) pipe_max = ad;
                    end else begin
                        a  = 2;
                        ad = int'(base_load_addr);
                    end
                    wr_cnt[a]++;
                    check("wr_asset", 32'(a), 32'(e.asset));
                    check("wr_addr", 32'(ad), 32'(e.idx));
                    check("wr_data", 32'(load_data), 32'(e.data));
                    check("wr_latency", 32'(cyc - e.cyc), 32'd1);
                    if (a == 2 && ad == 9599) check("done_with_last_wr", 32'(done), 32'd1);
                end
            end
            total_en += n_en;

            // Drive the next read word before adding a new burst: it can only start next cycle.
            if (inject) begin
                rd_valid = 1'b1;
                rd_data  = 16'hA5A5;
            end else if (pending.size() != 0) begin
                w        = pending.pop_front();
                rd_valid = 1'b1;
                rd_data  = img(w);
                if (!stale && !rst) begin
                    map_addr(w, a, idx);
                    e.asset = a;
                    e.idx   = idx;
                    e.data  = rd_data;
                    e.cyc   = cyc;
                    sb.push_back(e);
                    exp_sum[a] = exp_sum[a] + rd_data;
                end
                if (pending.size() == 0) stale = 1'b0;
            end else begin
                rd_valid = 1'b0;
                rd_data  = 16'h0000;
            end

            if (req_valid && req_ready) begin
                if (exp_req.size() == 0) begin
                    check("unexpected_req", 32'(req_addr), 32'd0);
                end else begin
                    r = exp_req.pop_front();
                    check("req_addr", 32'(req_addr), 32'(r.addr));
                    check("req_len", 32'(req_len), 32'(r.len));
                end
                map_addr(req_addr, a, idx);
                req_cnt[a]++;
                last_len[a]  = int'(req_len);
                last_addr[a] = req_addr;
                for (int i = 0; i < int'(req_len); i++) pending.push_back(req_addr + 24'(i));
            end
        end
    endtask

    task automatic pulse_start();
        @(posedge clk);
        #2 start = 1'b1;
        @(posedge clk);
        #2 start = 1'b0;
    endtask

    initial begin
        int en_before;
        rst       = 1'b1;
        start     = 1'b0;
        req_ready = 1'b0;
        rd_valid  = 1'b0;
        rd_data   = 16'h0000;
        reset_model();
        fork
            sdram_model();
        join_none

        // Reset state
        #15;
        check("rst_req_valid", 32'(req_valid), 32'd0);
        check("rst_req_addr", 32'(req_addr), 32'd0);
        check("rst_req_len", 32'(req_len), 32'd0);
        check("rst_load_data", 32'(load_data), 32'd0);
        check("rst_bird_en", 32'(bird_load_en), 32'd0);
        check("rst_pipe_en", 32'(pipe_load_en), 32'd0);
        check("rst_base_en", 32'(base_load_en), 32'd0);
        check("rst_bird_addr", 32'(bird_load_addr), 32'd0);
        check("rst_pipe_addr", 32'(pipe_load_addr), 32'd0);
        check("rst_base_addr", 32'(base_load_addr), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        @(posedge clk);
        #2 rst = 1'b0;

        // Read data arriving in IDLE is dropped
        inject = 1'b1;
        repeat (3) @(posedge clk);
        #2 inject = 1'b0;
        repeat (3) @(negedge clk);
        check("idle_word_dropped", 32'(total_en), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);

        // Full load, first request stalled 10 cycles
        pulse_start();
        @(negedge clk);
        check("busy_after_start", 32'(busy), 32'd1);
        for (int i = 0; i < 5; i++) begin
            if (req_valid) break;
            @(negedge clk);
        end
        check("first_req_valid", 32'(req_valid), 32'd1);
        check("first_req_addr", 32'(req_addr), 32'h200000);
        check("first_req_len", 32'(req_len), 32'd256);
        repeat (10) begin
            @(negedge clk);
            check("stall_req_valid", 32'(req_valid), 32'd1);
            check("stall_req_addr", 32'(req_addr), 32'h200000);
            check("stall_req_len", 32'(req_len), 32'd256);
            check("stall_no_words", 32'(pending.size()), 32'd0);
        end
        @(posedge clk);
        #2 req_ready = 1'b1;

        for (int i = 0; i < 2000; i++) begin
            if (wr_cnt[0] >= 100) break;
            @(negedge clk);
        end
        check("bird_progress", 32'(wr_cnt[0] >= 100), 32'd1);
        pulse_start();
        @(negedge clk);
        check("restart_ignored_busy", 32'(busy), 32'd1);

        for (int i = 0; i < 70000; i++) begin
            if (done) break;
            @(negedge clk);
        end
        check("done_reached", 32'(done), 32'd1);
        repeat (3) @(negedge clk);
        check("bird_wr_cnt", 32'(wr_cnt[0]), 32'd5250);
        check("pipe_wr_cnt", 32'(wr_cnt[1]), 32'd40000);
        check("base_wr_cnt", 32'(wr_cnt[2]), 32'd9600);
        check("pipe_max_addr", 32'(pipe_max), 32'h9C3F);
        check("bird_req_cnt", 32'(req_cnt[0]), 32'd21);
        check("bird_last_addr", 32'(last_addr[0]), 32'h201400);
        check("bird_last_len", 32'(last_len[0]), 32'd130);
        check("pipe_last_len", 32'(last_len[1]), 32'd64);
        check("base_last_len", 32'(last_len[2]), 32'd128);
        check("sb_drained", 32'(sb.size()), 32'd0);
        check("reqs_all_seen", 32'(exp_req.size()), 32'd0);
        check("done_held", 32'(done), 32'd1);
        check("busy_after_done", 32'(busy), 32'd0);
        check("req_idle_after_done", 32'(req_valid), 32'd0);
`ifdef TEXTURE_LOAD_CHECKSUM_EN
        check("bird_sum", 32'(bird_sum), 32'(exp_sum[0]));
        check("pipe_sum", 32'(pipe_sum), 32'(exp_sum[1]));
        check("base_sum", 32'(base_sum), 32'(exp_sum[2]));
`endif

        // Reset in the middle of the pipe phase
        reset_model();
        pulse_start();
        @(negedge clk);
        check("done_cleared_on_start", 32'(done), 32'd0);
        for (int i = 0; i < 10000; i++) begin
            @(negedge clk);
            if (pipe_load_en && pipe_load_addr == 16'd1000) break;
        end
        check("pipe1000_reached", 32'(pipe_load_addr), 32'd1000);
        #2 rst = 1'b1;
        #1;
        check("abort_bird_en", 32'(bird_load_en), 32'd0);
        check("abort_pipe_en", 32'(pipe_load_en), 32'd0);
        check("abort_base_en", 32'(base_load_en), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_req_valid", 32'(req_valid), 32'd0);
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        en_before = total_en;
        for (int i = 0; i < 400; i++) begin
            if (pending.size() == 0) break;
            @(negedge clk);
        end
        repeat (3) @(negedge clk);
        check("inflight_drained", 32'(pending.size()), 32'd0);
        check("inflight_dropped", 32'(total_en), 32'(en_before));
        check("done_after_abort", 32'(done), 32'd0);

        // Fresh start begins again at the bird, address 0
        reset_model();
        pulse_start();
        for (int i = 0; i < 600; i++) begin
            if (wr_cnt[0] >= 20) break;
            @(negedge clk);
        end
        check("restart_bird_cnt", 32'(wr_cnt[0] >= 20), 32'd1);
        check("restart_first_addr", 32'(first_bird_addr), 32'd0);
        check("restart_pipe_cnt", 32'(wr_cnt[1]), 32'd0);

        rst = 1'b1;
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/texture_load_ctrl.md
Name: texture_load_ctrl

Overview:
- Upstream feeder for the sprite renderer. After power-up it fetches the bird, pipe and base texture images from SDRAM and writes them word by word into the renderer's texture RAMs.
- Sequences the three assets in a fixed order: bird, then pipe, then base.
- Splits each asset into bounded SDRAM read bursts.
- Drives per-asset write enables and addresses on a shared data bus.
- Runs in the 50 MHz load-clock domain, which is the same clock as the renderer's texture write ports.

Parameters:
- BIRD_WORDS, 5250: bird image size in 16-bit words (3 frames of 50x35).
- PIPE_WORDS, 40000: pipe image size in words (80x500). The full image is streamed; the renderer keeps only what it needs.
- BASE_WORDS, 9600: base image size in words (64x150).
- BIRD_SDRAM_ADDR, 24'h200000: SDRAM word address of the bird image.
- PIPE_SDRAM_ADDR, 24'h202000: SDRAM word address of the pipe image.
- BASE_SDRAM_ADDR, 24'h20C000: SDRAM word address of the base image.
- BURST_LEN, 256: maximum words per read request; must be at least 1 and at most 256.

Ports:
- clk  in  1  50 MHz load clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse that begins a full load sequence.
- req_valid  out  1  SDRAM read request valid.
- req_ready  in  1  SDRAM controller accepts the request.
- req_addr  out  24  burst start word address.
- req_len  out  9  burst length in words, 1..256.
- rd_valid  in  1  read data word valid. There is no backpressure.
- rd_data  in  16  read data word.
- load_data  out  16  write data shared by all texture RAMs.
- bird_load_en  out  1  bird RAM write enable.
- bird_load_addr  out  13  bird RAM write address.
- pipe_load_en  out  1  pipe RAM write enable.
- pipe_load_addr  out  16  pipe RAM write address.
- base_load_en  out  1  base RAM write enable.
- base_load_addr  out  14  base RAM write address.
- busy  out  1  high from the cycle after an accepted start until the sequence finishes.
- done  out  1  high and held after all three assets have loaded.

Behaviour:
- Reset values: every output is 0; the FSM is in IDLE; all counters are cleared.
- Reset asserted mid-sequence: the block aborts immediately. done stays 0 until a new start completes. Any SDRAM data still in flight after reset releases is dropped, because the block is in IDLE.
- FSM states: IDLE, REQ, RECV, DONE.
  - IDLE or DONE with start=1: select asset=BIRD, set offset=0, clear done, raise busy, go to REQ.
  - start while busy is ignored.
- REQ:
  - req_valid=1.
  - req_addr = asset base address + offset.
  - req_len = min(BURST_LEN, asset words - offset).
  - req_addr and req_len stay stable while req_ready=0.
  - When req_valid and req_ready are both high, latch burst_cnt=req_len and go to RECV. req_valid drops in the next cycle.
- RECV:
  - Each rd_valid cycle captures rd_data and decrements burst_cnt.
  - One cycle later, load_data = the captured word and exactly one asset's load_en=1, with load address = the word's index within that asset (offset + position in burst).
  - Write latency from rd_valid to load_en is fixed at 1 cycle. Back-to-back rd_valid produces back-to-back enables.
  - When the final word of the burst is accepted:
    - if offset + len < asset words: advance offset and go to REQ;
    - otherwise, if there is another asset: move to it, reset offset=0 and go to REQ;
    - otherwise, after the base asset: go to DONE.
- DONE: done=1 and busy=0. The final load_en pulse is issued in the cycle DONE is entered.
- rd_valid seen outside RECV: the word is dropped with no enable.
- Address width: asset addresses never exceed word count - 1. The final pipe address is 39999 (16'h9C3F).
- Last burst of each asset at BURST_LEN=256: bird 130 words, pipe 64 words, base 128 words.

Optional Feature:
- Macro TEXTURE_LOAD_CHECKSUM_EN.
- When defined, the block adds outputs bird_sum, pipe_sum and base_sum, each 16 bits. Each is the modulo-2^16 sum of all words written for its asset. They clear on accepted start and on reset, and are valid while done=1.
- When not defined, these ports and adders are absent and the behaviour is otherwise identical.

Decomposition:
- Shared package texture_pkg holds:
  - the asset enum: BIRD=0, PIPE=1, BASE=2;
  - the word counts and SDRAM addresses as localparams;
  - the width constants: 24-bit SDRAM address, 9-bit length.
- One sub-module, burst_splitter, is a natural split. It takes asset words and the current offset and produces req_len and a last-burst flag. It is combinational plus an offset register.

Test Plan:
- Reset, then start with req_ready always 1 and rd_valid streaming every cycle:
  - exactly 5250 bird_load_en pulses, addresses 0..5249;
  - then 40000 pipe pulses, addresses 0..39999;
  - then 9600 base pulses, addresses 0..9599;
  - done=1 after the final base write.
- Request stream: the first request is addr 24'h200000, len 256. The bird issues 21 requests and its 21st is len 130 at 24'h201400. The pipe's last request is len 64. The base's last request is len 128.
- req_ready held low for 10 cycles: req_valid, req_addr and req_len stay constant; no words are accepted.
- rd_data=16'hA5A5 arriving with rd_valid in IDLE produces no load_en. A second start pulse in mid-sequence is ignored and the write counts are unchanged.
- rst asserted during the pipe phase at pipe address 1000: all enables drop the same cycle, busy=0 and done=0. A fresh start restarts the sequence at the bird, address 0.
- With TEXTURE_LOAD_CHECKSUM_EN and an image that is all 16'h0001: bird_sum=16'd5250, pipe_sum=16'd40000, base_sum=16'd9600.
